// File: rtl/alu_arbiter.sv
// Two requesters share one 4-bit ALU through an IDLE/EXEC/RESP sequencer with a held response port.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default build is round-robin.
module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic [CNT_W-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } req_t;

  state_t     state, state_nxt;
  req_t       cap, sel;
  logic       grant, hs;
  logic [3:0] alu_res;
  logic       alu_c;

  // grant is the index that would win this cycle; it only matters in IDLE
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant = ~req0_valid;
`else
  logic last_grant;
  assign grant = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
`endif

  assign sel = grant ? '{id: 1'b1, op: req1_op, a: req1_a, b: req1_b}
                     : '{id: 1'b0, op: req0_op, a: req0_a, b: req0_b};
  assign hs  = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        if (req0_ready || req1_ready) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operates only on the captured operands, never on live inputs
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (cap.op)
      3'd0: alu_res = cap.a & cap.b;
      3'd1: alu_res = cap.a | cap.b;
      3'd2: alu_res = cap.a ^ cap.b;
      3'd3: alu_res = ~cap.a;
      3'd4: {alu_c, alu_res} = {1'b0, cap.a} + {1'b0, cap.b};
      3'd5: begin
        alu_res = cap.a - cap.b;
        alu_c   = (cap.a < cap.b);
      end
      3'd6: {alu_c, alu_res} = {cap.a, 1'b0};
      3'd7: {alu_res, alu_c} = {1'b0, cap.a};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      ops_done   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (state == IDLE && hs) begin
        cap <= sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant <= grant;
`endif
      end
      if (state == EXEC) begin
        rsp_result <= alu_res;
        rsp_zero   <= (alu_res == 4'd0);
        rsp_carry  <= alu_c;
        rsp_id     <= cap.id;
        rsp_valid  <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + CNT_W'(1);
      end
    end
  end
endmodule
